serdes_deserializer_aligned: RTL and testbench

Parametrised serial-to-parallel converter for the serdes path. It shifts in one bit per enabled clock and finds word alignment by hunting for a comma symbol. Lock is declared after LOCK_COUNT consecutive aligned commas. Once locked, it emits WIDTH-bit words with a one-cycle valid strobe and drops lock when commas stop arriving.

---
 rtl/serdes_deserializer_aligned.sv | 154 +++++++++++++++
 tb/tb_serdes_deserializer_aligned.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serdes_deserializer_aligned.sv
// rtl/serdes_deserializer_aligned.sv - serial-to-parallel converter with comma-based word alignment
module serdes_deserializer_aligned #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA     = 8'hBC,
    parameter int              LOCK_COUNT = 4,
    parameter int              LOSS_WORDS = 16,
    parameter bit              MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             comma_det,
    output logic             active
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int GW = $clog2(LOSS_WORDS + 1);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_COUNT  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    comma_cnt_q, comma_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             comma_det_q, comma_det_d;
    logic             active_q, active_d;

    logic [WIDTH-1:0] sr_next;
    logic             boundary;
    logic             is_comma;

    // Candidate shift-register value if this edge samples a bit
    always_comb begin
        sr_next = sr_q;
        if (MSB_FIRST) begin
            sr_next = {sr_q[WIDTH-2:0], in};
        end else begin
            sr_next = {in, sr_q[WIDTH-1:1]};
        end
    end

    assign boundary = enb && (bit_cnt_q == BW'(WIDTH - 1));
    assign is_comma = (sr_next == COMMA);

    // Alignment FSM: next state, counters and output strobes
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        comma_det_d = 1'b0;

        if (enb) begin
            sr_d      = sr_next;
            bit_cnt_d = boundary ? '0 : bit_cnt_q + BW'(1);

            case (state_q)
                S_SEARCH: begin
                    // Hunt on every bit; a hit re-anchors the word boundary
                    if (is_comma) begin
                        comma_det_d = 1'b1;
                        bit_cnt_d   = '0;
                        comma_cnt_d = CW'(1);
                        if (LOCK_COUNT == 1) begin
                            state_d   = S_LOCKED;
                            gap_cnt_d = '0;
                        end else begin
                            state_d = S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    if (boundary) begin
                        if (is_comma) begin
                            comma_det_d = 1'b1;
                            comma_cnt_d = comma_cnt_q + CW'(1);
                            if (comma_cnt_q + CW'(1) == CW'(LOCK_COUNT)) begin
                                state_d   = S_LOCKED;
                                gap_cnt_d = '0;
                            end
                        end else begin
                            state_d     = S_SEARCH;
                            comma_cnt_d = '0;
                        end
                    end
                end
                S_LOCKED: begin
                    // Every aligned word is delivered, commas included
                    if (boundary) begin
                        data_out_d = sr_next;
                        valid_d    = 1'b1;
                        if (is_comma) begin
                            comma_det_d = 1'b1;
                            gap_cnt_d   = '0;
                        end else begin
                            gap_cnt_d = gap_cnt_q + GW'(1);
                            if (gap_cnt_q + GW'(1) == GW'(LOSS_WORDS)) begin
                                state_d = S_SEARCH;
                            end
                        end
                    end
                end
                default: state_d = S_SEARCH;
            endcase
        end

        active_d = (state_d == S_LOCKED);
    end

    // State and output registers; reset dominates everything including enb
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            gap_cnt_q   <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            comma_det_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            comma_det_q <= comma_det_d;
            active_q    <= active_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign comma_det = comma_det_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serdes_deserializer_aligned.sv
// tb/tb_serdes_deserializer_aligned.sv - directed self-checking bench for serdes_deserializer_aligned
module tb_serdes_deserializer_aligned;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enb_m = 1'b0, in_m = 1'b0;
    logic       enb_l = 1'b0, in_l = 1'b0;
    logic [7:0] data_m, data_l;
    logic       valid_m, valid_l, cd_m, cd_l, active_m, active_l;

    int total = 0;
    int bad = 0;
    int vcnt_m = 0, vcnt_l = 0, cdcnt_m = 0;

    always #5 clk = ~clk;

    serdes_deserializer_aligned #(
        .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .LOSS_WORDS(16), .MSB_FIRST(1'b1)
    ) dut_msb (
        .clk(clk), .reset(reset), .enb(enb_m), .in(in_m),
        .data_out(data_m), .valid(valid_m), .comma_det(cd_m), .active(active_m)
    );

    serdes_deserializer_aligned #(
        .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .LOSS_WORDS(16), .MSB_FIRST(1'b0)
    ) dut_lsb (
        .clk(clk), .reset(reset), .enb(enb_l), .in(in_l),
        .data_out(data_l), .valid(valid_l), .comma_det(cd_l), .active(active_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge pass, sample 1 time unit later
    task automatic step(input logic lsb, input logic e, input logic b);
        enb_m = ~lsb & e;
        in_m  = b;
        enb_l = lsb & e;
        in_l  = b;
        @(posedge clk);
        #1;
        vcnt_m  += int'(valid_m);
        vcnt_l  += int'(valid_l);
        cdcnt_m += int'(cd_m);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        reset = 1'b0;
        enb_m = 1'b0;
        enb_l = 1'b0;
    endtask

    // Sends a byte in the order the selected instance expects; gap_len idle
    // cycles are inserted just before bit number gap_pos
    task automatic send_word(input logic lsb, input logic [7:0] w, input int gap_pos, input int gap_len);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_pos) begin
                for (int g = 0; g < gap_len; g++) step(lsb, 1'b0, 1'b0);
            end
            step(lsb, 1'b1, lsb ? w[i] : w[7-i]);
        end
    endtask

    task automatic lock_up(input logic lsb);
        for (int k = 0; k < 4; k++) send_word(lsb, 8'hBC, -1, 0);
    endtask

    initial begin
        // 1: reset state
        do_reset(3);
        check("rst_data", 32'(data_m), 32'h00);
        check("rst_valid", 32'(valid_m), 32'h0);
        check("rst_comma", 32'(cd_m), 32'h0);
        check("rst_active", 32'(active_m), 32'h0);

        // 2: acquire lock after random preamble
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        cdcnt_m = 0;
        vcnt_m  = 0;
        for (int k = 0; k < 3; k++) begin
            send_word(1'b0, 8'hBC, -1, 0);
            check("acq_comma_pulse", 32'(cd_m), 32'h1);
        end
        check("acq_active_pre", 32'(active_m), 32'h0);
        send_word(1'b0, 8'hBC, -1, 0);
        check("acq_comma4_pulse", 32'(cd_m), 32'h1);
        check("acq_active", 32'(active_m), 32'h1);
        check("acq_comma_count", 32'(cdcnt_m), 32'd4);
        check("acq_no_valid", 32'(vcnt_m), 32'd0);
        send_word(1'b0, 8'hA5, -1, 0);
        check("a5_data", 32'(data_m), 32'hA5);
        check("a5_valid", 32'(valid_m), 32'h1);
        check("a5_comma", 32'(cd_m), 32'h0);
        check("a5_valid_count", 32'(vcnt_m), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check("a5_valid_drop", 32'(valid_m), 32'h0);

        // 3: broken lock sequence re-hunts
        do_reset(1);
        cdcnt_m = 0;
        vcnt_m  = 0;
        for (int k = 0; k < 3; k++) send_word(1'b0, 8'hBC, -1, 0);
        send_word(1'b0, 8'h00, -1, 0);
        check("brk_active_after_00", 32'(active_m), 32'h0);
        send_word(1'b0, 8'hBC, -1, 0);
        check("brk_final_comma", 32'(cd_m), 32'h1);
        check("brk_comma_count", 32'(cdcnt_m), 32'd4);
        check("brk_active", 32'(active_m), 32'h0);
        check("brk_no_valid", 32'(vcnt_m), 32'd0);

        // 4: loss of lock after 16 non-comma words
        do_reset(1);
        lock_up(1'b0);
        vcnt_m = 0;
        for (int k = 1; k <= 16; k++) begin
            send_word(1'b0, 8'h55, -1, 0);
            check("loss_valid", 32'(valid_m), 32'h1);
            check("loss_data", 32'(data_m), 32'h55);
            if (k == 15) check("loss_active_15", 32'(active_m), 32'h1);
        end
        check("loss_active_16", 32'(active_m), 32'h0);
        check("loss_valid_count", 32'(vcnt_m), 32'd16);
        send_word(1'b0, 8'h55, -1, 0);
        check("loss_17_no_valid", 32'(vcnt_m), 32'd16);
        check("loss_17_active", 32'(active_m), 32'h0);

        // 5: enb gaps, MSB first then LSB first
        do_reset(1);
        lock_up(1'b0);
        vcnt_m = 0;
        send_word(1'b0, 8'h3C, 4, 5);
        check("gap_msb_data", 32'(data_m), 32'h3C);
        check("gap_msb_valid", 32'(valid_m), 32'h1);
        check("gap_msb_count", 32'(vcnt_m), 32'd1);
        lock_up(1'b1);
        check("gap_lsb_active", 32'(active_l), 32'h1);
        vcnt_l = 0;
        send_word(1'b1, 8'h3C, 4, 5);
        check("gap_lsb_data", 32'(data_l), 32'h3C);
        check("gap_lsb_valid", 32'(valid_l), 32'h1);
        check("gap_lsb_count", 32'(vcnt_l), 32'd1);

        // 6: mid-word reset discards the partial word and the lock
        do_reset(1);
        lock_up(1'b0);
        send_word(1'b0, 8'hA5, -1, 0);
        check("mid_pre_data", 32'(data_m), 32'hA5);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        do_reset(1);
        check("mid_rst_active", 32'(active_m), 32'h0);
        check("mid_rst_data", 32'(data_m), 32'h00);
        vcnt_m  = 0;
        cdcnt_m = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        check("mid_no_valid", 32'(vcnt_m), 32'd0);
        check("mid_no_comma", 32'(cdcnt_m), 32'd0);
        check("mid_no_lock", 32'(active_m), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
